frame_mem_scheduler: RTL and testbench
======================================

Name: frame_mem_scheduler

Overview:
- Single-port frame-memory scheduler for the HDMI edge-detection path, in the pixel clock domain.
- Prefetches the frame in raster order (address 0 to WIDTH*HEIGHT-1) into a small pixel FIFO that drains one pixel per active_video cycle from the TMDS timing generator.
- Shares the same RAM port with a host write requester (image loader / edge filter writeback) through a deadline-aware priority arbiter.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- DATA_W, 8, pixel width in bits.
- FIFO_DEPTH, 16, prefetch FIFO entries (power of two, at least 4).
- LOW_WATER, 4, occupancy below which video reads take priority over host writes (must be less than FIFO_DEPTH).
- ADDR_W, $clog2(WIDTH*HEIGHT), derived memory address width.

Ports:
- pixel_clk  in  1  sole clock; all logic on its rising edge.
- n_rst  in  1  asynchronous active-low reset.
- active_video  in  1  from timing generator; each high cycle consumes one pixel.
- v_sync  in  1  from timing generator, active high; rising edge marks frame start.
- pix_data  out  DATA_W  pixel for the active_video cycle of the previous clock.
- underflow  out  1  sticky; pixel demanded while FIFO empty.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write granted this cycle (combinational grant).
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  DATA_W  host write data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after a read strobe.

Behaviour:
- Reset values: pix_data=0, underflow=0, wr_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. FIFO empty, rd_addr=0, in-flight flag=0, FSM in S_WAIT, v_sync history register=0.
- FSM states:
  - S_WAIT: no reads issued; host writes granted whenever wr_valid.
  - S_FETCH: reads and writes arbitrated as below.
  - S_DONE: rd_addr has reached WIDTH*HEIGHT; no reads, writes granted whenever wr_valid.
- FSM transitions: frame start (v_sync registered 0, now 1) from any state flushes the FIFO, sets rd_addr=0, kills any in-flight read return, and enters S_FETCH. In S_FETCH, issuing the read of address WIDTH*HEIGHT-1 moves the FSM to S_DONE.
- Occupancy = FIFO count + in-flight read (0 or 1).
- Arbitration each cycle in S_FETCH:
  - occ < LOW_WATER: read wins and wr_ready=0.
  - Otherwise, wr_valid high: write wins.
  - Otherwise, occ < FIFO_DEPTH: read issued.
  - Otherwise: memory idle.
- At most one RAM access per cycle.
- A read drives mem_en=1, mem_we=0, mem_addr=rd_addr, then increments rd_addr.
- A write drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. The write is complete when wr_valid and wr_ready are both high.
- mem_* outputs are combinational from the registered arbitration state.
- mem_rdata is pushed into the FIFO on the cycle after a read, unless that read was killed by a frame start.
- Pop happens on cycles with active_video=1 and FIFO not empty; the head is registered into pix_data (1-cycle latency, aligned with the timing generator's registered h_pos/n_pos).
- Push and pop in the same cycle leave the count unchanged. Push into a full FIFO cannot happen, because occupancy accounting prevents it.
- Pop request with FIFO empty: pix_data=0, underflow set and held until n_rst.
- Frame start coinciding with a push or pop: the flush wins, leaving FIFO empty, count 0 and pix_data=0.
- active_video outside S_FETCH/S_DONE with FIFO empty is treated as underflow.
- Host write to an address not yet prefetched is visible in the same frame. A write to an address already prefetched appears next frame.
- Reset mid-frame: all state returns to reset values immediately, with no RAM access until the next v_sync rise.

Test Plan:
- Reset, then v_sync pulse, no host traffic, RAM model mem[a]=a[7:0] → reads of addresses 0..15 issued back-to-back; FIFO holds 16 entries; mem_en stays 0 while occupancy is 16.
- Full frame of 640x480 active_video after prefetch → pix_data sequence 0,1,2,...,(307199 mod 256) each one cycle after active_video; underflow stays 0; FSM reaches S_DONE after address 307199.
- wr_valid held high continuously in S_FETCH → wr_ready=0 whenever occupancy<4. Writes are granted otherwise, and no underflow occurs at 1 pop/cycle.
- active_video asserted 2 cycles after v_sync rise (FIFO still filling) → underflow=1 and pix_data=0 on the starved cycle; underflow still 1 after the next frame start.
- v_sync rise one cycle after a read is issued (in-flight) → that return is discarded, FIFO count=0, next read address is 0.
- n_rst pulsed low mid-frame with FIFO half full → all outputs 0 during reset; after release no mem_en until the next v_sync rise.

Source files
------------

// File: rtl/frame_mem_scheduler.sv
// Frame-memory scheduler: prefetches the frame in raster order into a pixel FIFO
// for the video output and shares the single RAM port with host writes.
module frame_mem_scheduler #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4,
    parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic              pixel_clk,
    input  logic              n_rst,
    input  logic              active_video,
    input  logic              v_sync,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [OCC_W-1:0]  LOW_OCC   = OCC_W'(LOW_WATER);
    localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_WAIT,
        S_FETCH,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              vs_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

    logic              frame_start;
    logic              rd_issue;
    logic              wr_grant;
    logic              push;
    logic              pop;
    logic              empty;
    logic [OCC_W-1:0]  occ;

    // Arbitration, next-state and RAM port drive.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        frame_start = v_sync & ~vs_q;
        occ         = OCC_W'(count_q) + OCC_W'(inflight_q);
        rd_issue    = 1'b0;
        wr_grant    = 1'b0;
        state_d     = state_q;

        // The frame-start cycle never reads: rd_addr_q still belongs to the old frame.
        if (state_q == S_FETCH && !frame_start) begin
            if (occ < LOW_OCC) begin
                rd_issue = 1'b1;
            end else if (wr_valid) begin
                wr_grant = 1'b1;
            end else if (occ < FULL_OCC) begin
                rd_issue = 1'b1;
            end
        end else begin
            wr_grant = wr_valid & n_rst;
        end

        if (frame_start) begin
            state_d = S_FETCH;
        end else if (rd_issue && rd_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
        end

        rd_addr_d  = frame_start ? '0 : rd_addr_q + ADDR_W'(rd_issue);
        inflight_d = rd_issue;

        wr_ready  = wr_grant;
        mem_en    = rd_issue | wr_grant;
        mem_we    = wr_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_grant) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (rd_issue) begin
            mem_addr = rd_addr_q;
        end
    end

    // Pixel FIFO bookkeeping; a frame start flushes and overrides push/pop.
    always_comb begin
        empty       = (count_q == '0);
        push        = inflight_q & ~frame_start;
        pop         = active_video & ~empty & ~frame_start;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pix_data_d  = pix_data_q;
        underflow_d = underflow_q | (active_video & empty);

        if (frame_start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pix_data_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            if (active_video) begin
                pix_data_d = empty ? '0 : fifo_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            vs_q        <= 1'b0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pix_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            vs_q        <= v_sync;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pix_data_q  <= pix_data_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the FIFO storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign pix_data  = pix_data_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_frame_mem_scheduler.sv
// Bench for frame_mem_scheduler on a small 8x6 frame: a queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_frame_mem_scheduler;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int TOTAL = W * H;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LOW   = 4;
    localparam int AW    = $clog2(TOTAL);

    logic          pixel_clk = 1'b0;
    logic          n_rst;
    logic          active_video;
    logic          v_sync;
    logic [DW-1:0] pix_data;
    logic          underflow;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 pixel_clk = ~pixel_clk;

    frame_mem_scheduler #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .LOW_WATER (LOW)
    ) dut (
        .pixel_clk   (pixel_clk),
        .n_rst       (n_rst),
        .active_video(active_video),
        .v_sync      (v_sync),
        .pix_data    (pix_data),
        .underflow   (underflow),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame RAM driven by the DUT port: one-cycle read latency, contents a[7:0].
    logic [DW-1:0] ram [TOTAL];
    initial begin
        for (int i = 0; i < TOTAL; i++) ram[i] <= DW'(i);
        forever begin
            @(posedge pixel_clk);
            if (mem_en && mem_we && int'(mem_addr) < TOTAL) ram[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= (int'(mem_addr) < TOTAL) ? ram[mem_addr] : '0;
        end
    end

    // Reference model: frame contents, pixel queue, a pending read and a fetch pointer.
    logic [DW-1:0] shadow [TOTAL];
    logic [DW-1:0] fifo_m [$];
    bit            pend_m;
    logic [DW-1:0] pend_val;
    bit            fetching;
    int            next_addr;
    bit            vs_m;
    logic [DW-1:0] pix_m;
    bit            und_m;

    initial begin
        for (int i = 0; i < TOTAL; i++) shadow[i] = DW'(i);
        forever begin
            @(negedge pixel_clk);
            if (!n_rst) begin
                check("rst_pix_data", pix_data, 0);
                check("rst_underflow", underflow, 0);
                check("rst_wr_ready", wr_ready, 0);
                check("rst_mem_en", mem_en, 0);
                check("rst_mem_we", mem_we, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
                fifo_m.delete();
                pend_m    = 1'b0;
                fetching  = 1'b0;
                next_addr = 0;
                vs_m      = 1'b0;
                pix_m     = '0;
                und_m     = 1'b0;
            end else begin : model_step
                bit fs;
                bit exp_rd;
                bit exp_wr;
                int occ;
                fs     = v_sync && !vs_m;
                occ    = fifo_m.size() + (pend_m ? 1 : 0);
                exp_rd = 1'b0;
                exp_wr = 1'b0;
                if (fetching && !fs && next_addr < TOTAL) begin
                    if (occ < LOW) exp_rd = 1'b1;
                    else if (wr_valid) exp_wr = 1'b1;
                    else if (occ < DEPTH) exp_rd = 1'b1;
                end else begin
                    exp_wr = wr_valid;
                end

                check("pix_data", pix_data, pix_m);
                check("underflow", underflow, und_m);
                check("wr_ready", wr_ready, exp_wr);
                check("mem_en", mem_en, exp_rd || exp_wr);
                if (exp_rd || exp_wr) begin
                    check("mem_we", mem_we, exp_wr);
                    check("mem_addr", mem_addr, exp_wr ? wr_addr : AW'(next_addr));
                end
                if (exp_wr) check("mem_wdata", mem_wdata, wr_data);

                if (active_video && fifo_m.size() == 0) und_m = 1'b1;
                if (fs) begin
                    fifo_m.delete();
                    pend_m    = 1'b0;
                    next_addr = 0;
                    fetching  = 1'b1;
                    pix_m     = '0;
                end else begin
                    if (active_video) pix_m = (fifo_m.size() > 0) ? fifo_m.pop_front() : '0;
                    if (pend_m) fifo_m.push_back(pend_val);
                    pend_m = exp_rd;
                    if (exp_rd) begin
                        pend_val = shadow[next_addr];
                        next_addr++;
                    end
                end
                if (exp_wr) shadow[wr_addr] = wr_data;
                vs_m = v_sync;
            end
        end
    end

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic frame_start_pulse();
        v_sync = 1'b1;
        cycle();
        v_sync = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [DW-1:0] exp);
        active_video = 1'b1;
        cycle();
        active_video = 1'b0;
        check(name, pix_data, exp);
    endtask

    initial begin
        int            nreads;
        logic [DW-1:0] exp_px;
        n_rst        = 1'b0;
        active_video = 1'b0;
        v_sync       = 1'b0;
        wr_valid     = 1'b1;
        wr_addr      = '0;
        wr_data      = 8'h11;
        cycle(3);
        #3;
        check("reset_wr_ready_gated", wr_ready, 0);
        check("reset_mem_en_gated", mem_en, 0);
        wr_valid = 1'b0;
        cycle();
        n_rst = 1'b1;
        cycle(3);
        #3;
        check("idle_before_vsync", mem_en, 0);
        check("idle_pix", pix_data, 0);

        // Prefetch with no traffic: addresses 0..15 back to back, then idle at 16.
        frame_start_pulse();
        nreads = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (mem_en && !mem_we) begin
                check("prefetch_addr", mem_addr, nreads);
                nreads++;
            end
            cycle();
        end
        #3;
        check("prefetch_count", nreads, 16);
        check("idle_when_full", mem_en, 0);
        check("model_fill", fifo_m.size(), 16);

        // Full frame at one pixel per cycle.
        for (int k = 0; k < TOTAL; k++) begin
            active_video = 1'b1;
            cycle();
            check("frame_pix", pix_data, k);
        end
        active_video = 1'b0;
        check("frame_no_underflow", underflow, 0);
        cycle(2);
        #3;
        check("done_no_reads", mem_en, 0);

        // Host writes contend with prefetch: addr 2 already fetched, 40/41 not yet.
        frame_start_pulse();
        wr_valid = 1'b1;
        wr_addr  = AW'(40);
        wr_data  = 8'hA5;
        cycle(8);
        wr_addr  = AW'(2);
        wr_data  = 8'h5A;
        cycle(2);
        wr_valid = 1'b0;
        cycle(16);
        wr_valid = 1'b1;
        wr_addr  = AW'(41);
        wr_data  = 8'h3C;
        for (int k = 0; k < TOTAL; k++) begin
            exp_px = DW'(k);
            if (k == 40) exp_px = 8'hA5;
            if (k == 41) exp_px = 8'h3C;
            active_video = 1'b1;
            cycle();
            check("host_frame_pix", pix_data, exp_px);
        end
        active_video = 1'b0;
        wr_valid     = 1'b0;
        check("host_no_underflow", underflow, 0);

        // The write to an already-fetched address shows up next frame.
        frame_start_pulse();
        cycle(20);
        pop_check("next_frame_pix0", 8'h00);
        pop_check("next_frame_pix1", 8'h01);
        pop_check("next_frame_pix2", 8'h5A);
        pop_check("next_frame_pix3", 8'h03);

        // Frame start while read 0 is in flight: the return is discarded.
        frame_start_pulse();
        #3;
        check("kill_first_rd_en", mem_en, 1);
        check("kill_first_rd_addr", mem_addr, 0);
        cycle();
        v_sync = 1'b1;
        #3;
        check("kill_fs_no_read", mem_en, 0);
        cycle();
        v_sync = 1'b0;
        #3;
        check("kill_restart_en", mem_en, 1);
        check("kill_restart_addr", mem_addr, 0);
        check("kill_model_empty", fifo_m.size(), 0);
        cycle(20);
        pop_check("kill_pix0", 8'h00);
        pop_check("kill_pix1", 8'h01);
        pop_check("kill_pix2", 8'h5A);

        // Pixel demanded two cycles after frame start, before any data has landed.
        frame_start_pulse();
        cycle();
        pop_check("starve_pix", 8'h00);
        check("starve_underflow", underflow, 1);
        frame_start_pulse();
        cycle(3);
        check("underflow_sticky", underflow, 1);

        // Reset mid-frame with the FIFO half full.
        cycle(20);
        wr_valid     = 1'b1;
        wr_addr      = AW'(47);
        wr_data      = 8'h77;
        active_video = 1'b1;
        cycle(8);
        active_video = 1'b0;
        check("half_full_model", fifo_m.size(), 8);
        check("half_full_pix", pix_data, 7);
        n_rst = 1'b0;
        #3;
        check("midrst_pix", pix_data, 0);
        check("midrst_underflow", underflow, 0);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_mem_en", mem_en, 0);
        cycle(2);
        n_rst    = 1'b1;
        wr_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #3;
            check("post_reset_idle", mem_en, 0);
            cycle();
        end
        check("post_reset_underflow", underflow, 0);
        frame_start_pulse();
        cycle(20);
        pop_check("after_reset_pix0", 8'h00);
        pop_check("after_reset_pix1", 8'h01);
        pop_check("after_reset_pix2", 8'h5A);
        cycle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
